in128_out1536: RTL and testbench

// - AXI-Stream width upconverter: packs RATIO consecutive 128-bit input beats into one
//   1536-bit output word.
// - Sits on the write-back path: narrow DMA/PE result stream -> wide 1536-bit buffer.
// - Exact inverse of the 1536->128 downconverter: beat 0 lands in [127:0], beat 11 in
//   [1535:1408] (LSB-first).
// - Sustains 1 input beat/cycle with no bubble at word boundaries while downstream is ready.

---
 rtl/in128_out1536.sv | 140 ++++++++++++++
 tb/tb_in128_out1536.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/in128_out1536.sv
// in128_out1536: AXI-Stream width upconverter.
// Packs RATIO consecutive IN_W-bit beats (LSB-first) into one IN_W*RATIO-bit word.
// Beat 0 lands in the lowest slice and beat RATIO-1 in the highest slice.
// The output word is held in a register. The final beat of a word can be
// accepted in the same cycle that the held word is consumed, so a continuous
// input stream produces back-to-back output words with no bubble.
// Optional feature macro: IN128_OUT1536_TLAST_EN. When it is defined, an
// accepted s_axis_tlast beat closes a short word. The word's unfilled upper
// slices are zero, and m_axis_tlast marks the word.
module in128_out1536 #(
    parameter int IN_W  = 128,
    parameter int RATIO = 12,
    localparam int OUT_W = IN_W * RATIO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
`ifdef IN128_OUT1536_TLAST_EN
    ,
    input  logic             s_axis_tlast,
    output logic             m_axis_tlast
`endif
);

    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [IN_W-1:0]  acc_reg [RATIO-1];
    logic [OUT_W-1:0] out_reg;
    logic             out_vld_reg;
    logic [OUT_W-1:0] word_next;
    logic             close_beat;
    logic             accept;

    // A beat closes a word when it fills the last slice, or when it carries tlast (if enabled).
`ifdef IN128_OUT1536_TLAST_EN
    logic out_last_reg;
    assign close_beat = (cnt_reg == LAST_CNT) | s_axis_tlast;
`else
    assign close_beat = (cnt_reg == LAST_CNT);
`endif

    // A closing beat waits only while an unconsumed word occupies the output register.
    assign s_axis_tready = ~close_beat | ~out_vld_reg | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = out_reg;
    assign m_axis_tvalid = out_vld_reg;
`ifdef IN128_OUT1536_TLAST_EN
    assign m_axis_tlast  = out_last_reg;
`endif

    // Build the candidate output word from the accumulator slices and the incoming beat.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
            if (gi < RATIO - 1) begin : g_acc
`ifdef IN128_OUT1536_TLAST_EN
                // Use slices below cnt from the accumulator, the current beat at cnt, and zero padding above it.
                assign word_next[gi*IN_W +: IN_W] =
                    (CNT_W'(gi) < cnt_reg)  ? acc_reg[gi]  :
                    (CNT_W'(gi) == cnt_reg) ? s_axis_tdata : '0;
`else
                assign word_next[gi*IN_W +: IN_W] = acc_reg[gi];
`endif
            end else begin : g_top
`ifdef IN128_OUT1536_TLAST_EN
                assign word_next[gi*IN_W +: IN_W] = (cnt_reg == LAST_CNT) ? s_axis_tdata : '0;
`else
                assign word_next[gi*IN_W +: IN_W] = s_axis_tdata;
`endif
            end
        end
    endgenerate

    // Next beat count: advance on every accept, and wrap to zero when a word closes.
    always_comb begin
        cnt_next = cnt_reg;
        if (accept) begin
            cnt_next = close_beat ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    // Beat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Store each accepted non-final beat into the slice selected by the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                acc_reg[i] <= '0;
            end
        end else if (accept && (cnt_reg != LAST_CNT)) begin
            for (int i = 0; i < RATIO - 1; i++) begin
                if (cnt_reg == CNT_W'(i)) begin
                    acc_reg[i] <= s_axis_tdata;
                end
            end
        end
    end

    // Output holding register.
    // A closing beat loads a new word, which also replaces a word consumed in the same cycle.
    // A handshake that loads no new word empties the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg     <= '0;
            out_vld_reg <= 1'b0;
        end else if (accept && close_beat) begin
            out_reg     <= word_next;
            out_vld_reg <= 1'b1;
        end else if (m_axis_tready) begin
            out_vld_reg <= 1'b0;
        end
    end

`ifdef IN128_OUT1536_TLAST_EN
    // The packet-end flag travels with the word it closes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_last_reg <= 1'b0;
        end else if (accept && close_beat) begin
            out_last_reg <= s_axis_tlast;
        end
    end
`endif

endmodule

// File: tb/tb_in128_out1536.sv
// Testbench for in128_out1536.
// A reference model collects accepted beats and pushes each expected word into a queue.
// A separate monitor pops from the queue and compares on every output handshake.
module tb_in128_out1536;

    localparam int IN_W  = 128;
    localparam int RATIO = 12;
    localparam int OUT_W = IN_W * RATIO;
`ifdef IN128_OUT1536_TLAST_EN
    localparam bit TL = 1'b1;
`else
    localparam bit TL = 1'b0;
`endif

    typedef struct {
        logic [OUT_W-1:0] d;
        bit               last;
    } word_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IN_W-1:0]  s_tdata = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tlast = 1'b0;
    logic             s_tready;
    logic [OUT_W-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic             fixed_rdy = 1'b1;
    logic             rand_rdy = 1'b0;
    logic             rnd_rdy_bit = 1'b0;

    assign m_tready = rand_rdy ? rnd_rdy_bit : fixed_rdy;

    in128_out1536 dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
`ifdef IN128_OUT1536_TLAST_EN
        ,
        .s_axis_tlast  (s_tlast),
        .m_axis_tlast  (m_tlast)
`endif
    );
`ifndef IN128_OUT1536_TLAST_EN
    assign m_tlast = 1'b0;
`endif

    int               n_vec = 0;
    int               n_err = 0;
    int               cyc = 0;
    int               stalls = 0;
    int               words_rx = 0;
    bit               track_lat = 1'b0;
    logic [OUT_W-1:0] last_word = '0;
    bit               last_last = 1'b0;
    logic [IN_W-1:0]  beats[$];
    word_t            exp_q[$];
    int               exp_vcyc[$];

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        rnd_rdy_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_word(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        int k;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            k = 0;
            while (k < RATIO - 1 && act[k*IN_W +: IN_W] === exp[k*IN_W +: IN_W]) k++;
            $display("FAIL %s: slice %0d got %h expected %h (cycle %0d)", name, k,
                     act[k*IN_W +: IN_W], exp[k*IN_W +: IN_W], cyc);
        end
    endtask

    task automatic miss(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event expected one (cycle %0d)", name, cyc);
    endtask

    // Reference model: a word is the accepted beats laid out LSB-first, closed by the count (or by tlast).
    initial forever begin
        @(negedge clk);
        if (rst) begin
            beats.delete();
            exp_q.delete();
            exp_vcyc.delete();
        end else begin
            if (s_tvalid && !s_tready) stalls++;
            if (s_tvalid && s_tready) begin
                beats.push_back(s_tdata);
                if (beats.size() == RATIO || (TL && s_tlast)) begin
                    word_t w;
                    w.d = '0;
                    for (int k = 0; k < beats.size(); k++) begin
                        w.d = w.d | (OUT_W'(beats[k]) << (IN_W * k));
                    end
                    w.last = TL && s_tlast;
                    exp_q.push_back(w);
                    if (track_lat) exp_vcyc.push_back(cyc + 1);
                    beats.delete();
                end
            end
        end
    end

    // Monitor: scoreboard pop on handshake, AXIS hold rule, latency when downstream is always ready.
    initial begin
        bit               hold_pend;
        logic [OUT_W-1:0] hold_data;
        word_t            w;
        hold_pend = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 64'(m_tvalid), 64'd1);
                    chk_word("hold_data", m_tdata, hold_data);
                end
                if (track_lat && m_tvalid) begin
                    if (exp_vcyc.size() == 0) miss("latency_extra_valid");
                    else chk("latency", 64'(cyc), 64'(exp_vcyc.pop_front()));
                end
                if (m_tvalid && m_tready) begin
                    words_rx++;
                    last_word = m_tdata;
                    last_last = m_tlast;
                    if (exp_q.size() == 0) begin
                        miss("unexpected_word");
                    end else begin
                        w = exp_q.pop_front();
                        chk_word("word", m_tdata, w.d);
                        if (TL) chk("tlast", 64'(m_tlast), 64'(w.last));
                    end
                end
                hold_pend = m_tvalid && !m_tready;
                hold_data = m_tdata;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input bit last);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 300) begin
                miss("send_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) miss("drain_timeout");
        idle(3);
    endtask

    initial begin
        logic [IN_W-1:0]  fresh0;
        logic [OUT_W-1:0] e6;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tvalid", 64'(m_tvalid), 64'd0);
        chk_word("reset_tdata", m_tdata, '0);
        chk("reset_tready", 64'(s_tready), 64'd1);
        chk("reset_tlast", 64'(m_tlast), 64'd0);
        @(posedge clk);
        #1;

        // One word built from beats 0..11.
        track_lat = 1'b1;
        words_rx = 0;
        for (int k = 0; k < RATIO; k++) send(IN_W'(k), 1'b0);
        drain();
        chk("t1_words", 64'(words_rx), 64'd1);
        chk("t1_lat_left", 64'(exp_vcyc.size()), 64'd0);
        for (int k = 0; k < RATIO; k++) chk("t1_slice", 64'(last_word[k*IN_W +: IN_W]), 64'(k));

        // 48 continuous beats: no stall, four words.
        stalls = 0;
        words_rx = 0;
        for (int k = 0; k < 4 * RATIO; k++) send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drain();
        chk("t2_stalls", 64'(stalls), 64'd0);
        chk("t2_words", 64'(words_rx), 64'd4);
        chk("t2_lat_left", 64'(exp_vcyc.size()), 64'd0);
        track_lat = 1'b0;

        // Downstream blocked: only beat 23 may stall.
        words_rx = 0;
        stalls = 0;
        fixed_rdy = 1'b0;
        for (int k = 0; k < 2 * RATIO - 1; k++) send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        chk("t3_early_stalls", 64'(stalls), 64'd0);
        s_tvalid = 1'b1;
        s_tdata  = {$urandom, $urandom, $urandom, $urandom};
        repeat (4) begin
            @(negedge clk);
            chk("t3_final_stall", 64'(s_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        fixed_rdy = 1'b1;
        @(negedge clk);
        chk("t3_release", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        drain();
        chk("t3_words", 64'(words_rx), 64'd2);

        // Random valid/ready, 1200 beats.
        words_rx = 0;
        rand_rdy = 1'b1;
        for (int k = 0; k < 100 * RATIO; k++) begin
            while ($urandom_range(0, 1) == 1) idle(1);
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        drain();
        rand_rdy = 1'b0;
        chk("t4_words", 64'(words_rx), 64'd100);

        // Reset mid-word, then a fresh word.
        words_rx = 0;
        for (int k = 0; k < 5; k++) send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t5_valid_in_reset", 64'(m_tvalid), 64'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        fresh0 = {$urandom, $urandom, $urandom, $urandom};
        send(fresh0, 1'b0);
        for (int k = 1; k < RATIO; k++) send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drain();
        chk("t5_words", 64'(words_rx), 64'd1);
        chk("t5_slice0", last_word[63:0], fresh0[63:0]);

`ifdef IN128_OUT1536_TLAST_EN
        // Short packet closed by tlast, then a full word.
        words_rx = 0;
        send(IN_W'('hA), 1'b0);
        send(IN_W'('hB), 1'b0);
        send(IN_W'('hC), 1'b1);
        drain();
        e6 = '0;
        e6[127:0]   = IN_W'('hA);
        e6[255:128] = IN_W'('hB);
        e6[383:256] = IN_W'('hC);
        chk_word("t6_short_word", last_word, e6);
        chk("t6_short_tlast", 64'(last_last), 64'd1);
        for (int k = 0; k < RATIO; k++) send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        drain();
        chk("t6_full_tlast", 64'(last_last), 64'd0);
        chk("t6_words", 64'(words_rx), 64'd2);
`else
        e6 = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
